// File: rtl/asrm_bus_arbiter_pkg.sv
// Shared types and helpers for the two-master memory-port arbiter.
// State and grant encodings, plus counter width helpers.
package asrm_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_ACK    = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  function automatic int starve_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int lat_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/asrm_arb_select.sv
// Fixed-priority master pick with a bounded starvation counter.
// Master 1 wins a tie once master 0 has won max_starve ties in a row.
module asrm_arb_select
  import asrm_bus_arbiter_pkg::*;
#(
  parameter int max_starve = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       take,
  output logic [1:0] pick
);

  localparam int CW = starve_w(max_starve);
  localparam logic [CW-1:0] CMAX = CW'(max_starve);

  logic [CW-1:0] starve_cnt;

  always_comb begin
    pick = GRANT_NONE;
    unique case ({m1_req, m0_req})
      2'b01:   pick = GRANT_M0;
      2'b10:   pick = GRANT_M1;
      2'b11:   pick = (starve_cnt == CMAX)
                      ? GRANT_M1 : GRANT_M0;
      default: pick = GRANT_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (take && pick != GRANT_NONE) begin
      if (pick == GRANT_M1 || !m1_req)
        starve_cnt <= '0;
      else if (starve_cnt != CMAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/asrm_bus_arbiter.sv
// Two-master arbiter for the single system-memory port.
// IDLE -> ACCESS (mem_latency cycles) -> ACK, one-cycle ack to owner.
module asrm_bus_arbiter
  import asrm_bus_arbiter_pkg::*;
#(
  parameter int wordsize    = 16,
  parameter int mem_latency = 1,
  parameter int max_starve  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m0_wdata,
  input  logic                m0_we,
  output logic [wordsize-1:0] m0_rdata,
  output logic                m0_ack,
  input  logic                m1_req,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_wdata,
  input  logic                m1_we,
  output logic [wordsize-1:0] m1_rdata,
  output logic                m1_ack,
  output logic [wordsize-1:0] mem_addr,
  output logic [wordsize-1:0] mem_data_out,
  output logic                mem_write_en,
  input  logic [wordsize-1:0] mem_data_in,
  output logic [1:0]          grant
);

  localparam int LW = lat_w(mem_latency);
  localparam logic [LW-1:0] LAT_LOAD = LW'(mem_latency - 1);

  arb_state_t    state;
  logic [LW-1:0] lat_cnt;
  logic          we_q;
  logic [1:0]    pick;
  logic          take;

  assign take = (state == ARB_IDLE);

  asrm_arb_select #(
    .max_starve(max_starve)
  ) u_sel (
    .clk    (clk),
    .reset  (reset),
    .m0_req (m0_req),
    .m1_req (m1_req),
    .take   (take),
    .pick   (pick)
  );

  // mem_addr/mem_data_out double as the latched request, so an idle
  // bus naturally holds the last transaction's values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ARB_IDLE;
      grant        <= GRANT_NONE;
      lat_cnt      <= '0;
      we_q         <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_write_en <= 1'b0;
    end else begin
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      mem_write_en <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (pick != GRANT_NONE) begin
            state   <= ARB_ACCESS;
            grant   <= pick;
            lat_cnt <= LAT_LOAD;
            if (pick == GRANT_M1) begin
              mem_addr     <= m1_addr;
              mem_data_out <= m1_wdata;
              we_q         <= m1_we;
              mem_write_en <= m1_we;
            end else begin
              mem_addr     <= m0_addr;
              mem_data_out <= m0_wdata;
              we_q         <= m0_we;
              mem_write_en <= m0_we;
            end
          end
        end
        ARB_ACCESS: begin
          if (lat_cnt == '0) begin
            state  <= ARB_ACK;
            m0_ack <= grant[0];
            m1_ack <= grant[1];
            if (!we_q && grant[0])
              m0_rdata <= mem_data_in;
            if (!we_q && grant[1])
              m1_rdata <= mem_data_in;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ARB_ACK: begin
          state <= ARB_IDLE;
          grant <= GRANT_NONE;
        end
        default: begin
          state <= ARB_IDLE;
          grant <= GRANT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asrm_bus_arbiter.sv
// Directed bench for asrm_bus_arbiter: latency-2 and latency-1 instances.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_asrm_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_m0_req = 0, a_m0_we = 0, a_m1_req = 0, a_m1_we = 0;
  logic [15:0] a_m0_addr = 0, a_m0_wdata = 0;
  logic [15:0] a_m1_addr = 0, a_m1_wdata = 0;
  logic [15:0] a_mem_in = 0;
  logic [15:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_dout;
  logic        a_m0_ack, a_m1_ack, a_mem_we;
  logic [1:0]  a_grant;

  logic        b_m0_req = 0, b_m0_we = 0, b_m1_req = 0, b_m1_we = 0;
  logic [15:0] b_m0_addr = 0, b_m0_wdata = 0;
  logic [15:0] b_m1_addr = 0, b_m1_wdata = 0;
  logic [15:0] b_mem_in = 0;
  logic [15:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_dout;
  logic        b_m0_ack, b_m1_ack, b_mem_we;
  logic [1:0]  b_grant;

  asrm_bus_arbiter #(
    .wordsize(16), .mem_latency(2), .max_starve(2)
  ) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(a_m0_req), .m0_addr(a_m0_addr),
    .m0_wdata(a_m0_wdata), .m0_we(a_m0_we),
    .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack),
    .m1_req(a_m1_req), .m1_addr(a_m1_addr),
    .m1_wdata(a_m1_wdata), .m1_we(a_m1_we),
    .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack),
    .mem_addr(a_mem_addr), .mem_data_out(a_mem_dout),
    .mem_write_en(a_mem_we), .mem_data_in(a_mem_in),
    .grant(a_grant)
  );

  asrm_bus_arbiter #(
    .wordsize(16), .mem_latency(1), .max_starve(2)
  ) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(b_m0_req), .m0_addr(b_m0_addr),
    .m0_wdata(b_m0_wdata), .m0_we(b_m0_we),
    .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
    .m1_req(b_m1_req), .m1_addr(b_m1_addr),
    .m1_wdata(b_m1_wdata), .m1_we(b_m1_we),
    .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
    .mem_addr(b_mem_addr), .mem_data_out(b_mem_dout),
    .mem_write_en(b_mem_we), .mem_data_in(b_mem_in),
    .grant(b_grant)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [1:0] seq [6];

  initial begin
    seq[0] = 2'b01; seq[1] = 2'b01; seq[2] = 2'b10;
    seq[3] = 2'b01; seq[4] = 2'b01; seq[5] = 2'b10;

    // reset state
    tick(); tick();
    chk("rst_grant", 32'(a_grant), 32'h0);
    chk("rst_ack0", 32'(a_m0_ack), 32'h0);
    chk("rst_ack1", 32'(a_m1_ack), 32'h0);
    chk("rst_we", 32'(a_mem_we), 32'h0);
    chk("rst_addr", 32'(a_mem_addr), 32'h0);
    chk("rst_dout", 32'(a_mem_dout), 32'h0);
    chk("rst_rd0", 32'(a_m0_rdata), 32'h0);
    chk("rst_rd1", 32'(a_m1_rdata), 32'h0);
    chk("rst_b_grant", 32'(b_grant), 32'h0);
    reset = 1'b1;
    tick();

    // m0 read 0x0040 -> 0xBEEF
    a_m0_req = 1; a_m0_addr = 16'h0040; a_m0_we = 0;
    a_mem_in = 16'hBEEF;
    tick();
    chk("rd_c1_grant", 32'(a_grant), 32'h1);
    chk("rd_c1_addr", 32'(a_mem_addr), 32'h0040);
    chk("rd_c1_ack", 32'(a_m0_ack), 32'h0);
    chk("rd_c1_we", 32'(a_mem_we), 32'h0);
    tick();
    chk("rd_c2_addr", 32'(a_mem_addr), 32'h0040);
    chk("rd_c2_grant", 32'(a_grant), 32'h1);
    chk("rd_c2_ack", 32'(a_m0_ack), 32'h0);
    tick();
    chk("rd_c3_ack", 32'(a_m0_ack), 32'h1);
    chk("rd_c3_rdata", 32'(a_m0_rdata), 32'hBEEF);
    chk("rd_c3_grant", 32'(a_grant), 32'h1);
    a_m0_req = 0;
    tick();
    chk("rd_c4_ack", 32'(a_m0_ack), 32'h0);
    chk("rd_c4_grant", 32'(a_grant), 32'h0);
    chk("rd_c4_hold", 32'(a_mem_addr), 32'h0040);

    // m1 write 0x0100 <- 0x1234
    a_m1_req = 1; a_m1_addr = 16'h0100;
    a_m1_wdata = 16'h1234; a_m1_we = 1;
    tick();
    chk("wr_c1_we", 32'(a_mem_we), 32'h1);
    chk("wr_c1_dout", 32'(a_mem_dout), 32'h1234);
    chk("wr_c1_grant", 32'(a_grant), 32'h2);
    tick();
    chk("wr_c2_we", 32'(a_mem_we), 32'h0);
    chk("wr_c2_dout", 32'(a_mem_dout), 32'h1234);
    tick();
    chk("wr_c3_ack1", 32'(a_m1_ack), 32'h1);
    chk("wr_c3_ack0", 32'(a_m0_ack), 32'h0);
    chk("wr_c3_rd1", 32'(a_m1_rdata), 32'h0);
    a_m1_req = 0; a_m1_we = 0;
    tick();
    chk("wr_c4_ack1", 32'(a_m1_ack), 32'h0);
    chk("wr_c4_grant", 32'(a_grant), 32'h0);

    // both request together: m0 first, then m1
    a_m0_req = 1; a_m0_addr = 16'h0200;
    a_m1_req = 1; a_m1_addr = 16'h0300;
    a_mem_in = 16'h1111;
    tick();
    chk("both_c1_grant", 32'(a_grant), 32'h1);
    chk("both_c1_addr", 32'(a_mem_addr), 32'h0200);
    tick(); tick();
    chk("both_c3_ack0", 32'(a_m0_ack), 32'h1);
    chk("both_c3_rd0", 32'(a_m0_rdata), 32'h1111);
    a_m0_req = 0; a_mem_in = 16'h2222;
    tick();
    chk("both_c4_grant", 32'(a_grant), 32'h0);
    tick();
    chk("both_c5_grant", 32'(a_grant), 32'h2);
    chk("both_c5_addr", 32'(a_mem_addr), 32'h0300);
    tick(); tick();
    chk("both_c7_ack1", 32'(a_m1_ack), 32'h1);
    chk("both_c7_rd1", 32'(a_m1_rdata), 32'h2222);
    chk("both_c7_rd0", 32'(a_m0_rdata), 32'h1111);
    a_m1_req = 0;
    tick();

    // continuous contention: m0, m0, m1, m0, m0, m1
    a_m0_req = 1; a_m1_req = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("starve_grant%0d", i),
          32'(a_grant), 32'(seq[i]));
      tick(); tick();
      chk($sformatf("starve_ack%0d", i),
          32'({a_m1_ack, a_m0_ack}), 32'(seq[i]));
      tick();
    end
    a_m0_req = 0; a_m1_req = 0;
    tick();
    chk("starve_idle", 32'(a_grant), 32'h0);

    // reset in second ACCESS cycle of an m0 write
    a_m0_req = 1; a_m0_we = 1;
    a_m0_addr = 16'h0050; a_m0_wdata = 16'hCAFE;
    tick();
    chk("rw_c1_we", 32'(a_mem_we), 32'h1);
    tick();
    reset = 1'b0;
    tick();
    chk("rw_rst_grant", 32'(a_grant), 32'h0);
    chk("rw_rst_ack", 32'(a_m0_ack), 32'h0);
    chk("rw_rst_we", 32'(a_mem_we), 32'h0);
    chk("rw_rst_addr", 32'(a_mem_addr), 32'h0);
    reset = 1'b1;
    tick();
    chk("rw_r1_we", 32'(a_mem_we), 32'h1);
    chk("rw_r1_grant", 32'(a_grant), 32'h1);
    chk("rw_r1_dout", 32'(a_mem_dout), 32'hCAFE);
    chk("rw_r1_addr", 32'(a_mem_addr), 32'h0050);
    tick();
    chk("rw_r2_we", 32'(a_mem_we), 32'h0);
    tick();
    chk("rw_r3_ack", 32'(a_m0_ack), 32'h1);
    chk("rw_r3_we", 32'(a_mem_we), 32'h0);
    chk("rw_r3_rd0", 32'(a_m0_rdata), 32'h0);
    a_m0_req = 0; a_m0_we = 0;
    tick();
    chk("rw_r4_ack", 32'(a_m0_ack), 32'h0);

    // latency 1: m1 back-to-back reads
    b_m1_req = 1; b_m1_addr = 16'h0010; b_m1_we = 0;
    b_mem_in = 16'hAAAA;
    tick();
    chk("l1_c1_addr", 32'(b_mem_addr), 32'h0010);
    chk("l1_c1_we", 32'(b_mem_we), 32'h0);
    chk("l1_c1_ack", 32'(b_m1_ack), 32'h0);
    tick();
    chk("l1_c2_ack", 32'(b_m1_ack), 32'h1);
    chk("l1_c2_rd", 32'(b_m1_rdata), 32'hAAAA);
    b_m1_addr = 16'h0011; b_mem_in = 16'h5555;
    tick();
    chk("l1_c3_ack", 32'(b_m1_ack), 32'h0);
    chk("l1_c3_grant", 32'(b_grant), 32'h0);
    tick();
    chk("l1_c4_addr", 32'(b_mem_addr), 32'h0011);
    chk("l1_c4_we", 32'(b_mem_we), 32'h0);
    chk("l1_c4_grant", 32'(b_grant), 32'h2);
    tick();
    chk("l1_c5_ack", 32'(b_m1_ack), 32'h1);
    chk("l1_c5_rd", 32'(b_m1_rdata), 32'h5555);
    chk("l1_c5_ack0", 32'(b_m0_ack), 32'h0);
    b_m1_req = 0;
    tick();
    chk("l1_c6_grant", 32'(b_grant), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
